// File: rtl/add_share_arb_if.sv
// Bundle between requesters, the shared adder and the add_share_arb controller.
// The slave side is the controller; master is the surrounding environment.
interface add_share_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [DW-1:0]      add_a;
  logic [DW-1:0]      add_b;
  logic [DW:0]        add_sum;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW:0]        rsp_sum;
  logic [IDW-1:0]     rsp_id;
  logic [7:0]         ops_cnt;

  modport master (
    output req_valid, req_a, req_b, add_sum, rsp_ready,
    input  req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id, ops_cnt
  );

  modport slave (
    input  req_valid, req_a, req_b, add_sum, rsp_ready,
    output req_ready, add_a, add_b, rsp_valid, rsp_sum, rsp_id, ops_cnt
  );
endinterface

// File: rtl/add_share_arb.sv
// Round-robin controller sharing one combinational adder among NREQ requesters:
// grant, register operands, capture the sum, return it with a tagged response.
module add_share_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  add_share_arb_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_found;
  logic [IDW:0]   cand_w;
  logic [IDW-1:0] cand;
  logic [DW-1:0]  op_a;
  logic [DW-1:0]  op_b;
  logic           req_hs;
  logic           rsp_hs;

  // Rotating-priority search starting at ptr; first valid requester wins.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // updated value; clocked blocks use '<=' so all registers update together.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand_w    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_w = {1'b0, ptr} + (IDW+1)'(k);
      if (cand_w >= (IDW+1)'(NREQ)) cand_w = cand_w - (IDW+1)'(NREQ);
      cand = cand_w[IDW-1:0];
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_id) begin
        op_a = bus.req_a[i*DW +: DW];
        op_b = bus.req_b[i*DW +: DW];
      end
    end
  end

  assign req_hs = rst_n && (state == IDLE) && gnt_found;
  assign rsp_hs = (state == RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    if (req_hs) bus.req_ready[gnt_id] = 1'b1;
  end

  // Datapath: operands hold their last values outside a grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr           <= '0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_sum   <= '0;
      bus.rsp_id    <= '0;
      bus.ops_cnt   <= '0;
    end else begin
      if (req_hs) begin
        bus.add_a  <= op_a;
        bus.add_b  <= op_b;
        bus.rsp_id <= gnt_id;
      end
      if (state == EXEC) begin
        bus.rsp_sum   <= bus.add_sum;
        bus.rsp_valid <= 1'b1;
      end
      if (rsp_hs) begin
        bus.rsp_valid <= 1'b0;
        ptr           <= (bus.rsp_id == IDW'(NREQ-1)) ? '0 : bus.rsp_id + 1'b1;
        bus.ops_cnt   <= bus.ops_cnt + 8'd1;
      end
    end
  end

  // Protocol invariants; no hardware is generated for these.
  a_ready_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));
  a_ready_idle:   assert property (@(posedge clk) (bus.req_ready != '0) |-> (state == IDLE));
  a_rsp_stable:   assert property (@(posedge clk) disable iff (!rst_n)
                    (bus.rsp_valid && !bus.rsp_ready) |=>
                    (bus.rsp_valid && $stable(bus.rsp_sum) && $stable(bus.rsp_id)));
endmodule

// File: tb/tb_add_share_arb.sv
// Directed testbench for add_share_arb: inputs change on the falling edge,
// outputs are sampled 1 time unit later, well before the next rising edge.
module tb_add_share_arb;
  localparam int NREQ = 4;
  localparam int DW   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_ops  = 0;

  add_share_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  // Behavioural stand-in for the shared combinational adder.
  assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  add_share_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.ops_cnt !== 8'd0) $display("FAIL reset_ops_cnt: got %0d want 0", bus.ops_cnt); else n_pass++;
    n_checks++; if (bus.add_a !== 4'd0) $display("FAIL reset_add_a: got %0d want 0", bus.add_a); else n_pass++;
    n_checks++; if (bus.add_b !== 4'd0) $display("FAIL reset_add_b: got %0d want 0", bus.add_b); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 4'b0000;
    exp_ops = 0;
  endtask

  task automatic test_single();
    set_op(0, 4'd4, 4'd4);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    n_checks++; if (bus.add_a !== 4'd4) $display("FAIL single_add_a: got %0d want 4", bus.add_a); else n_pass++;
    n_checks++; if (bus.add_b !== 4'd4) $display("FAIL single_add_b: got %0d want 4", bus.add_b); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b want 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_sum !== 5'd8) $display("FAIL single_rsp_sum: got %0d want 8", bus.rsp_sum); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd0) $display("FAIL single_rsp_id: got %0d want 0", bus.rsp_id); else n_pass++;
    @(negedge clk); #1;
    exp_ops = 1;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_rsp_clear: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.ops_cnt !== 8'(exp_ops)) $display("FAIL single_ops_cnt: got %0d want %0d", bus.ops_cnt, exp_ops); else n_pass++;
  endtask

  // All four request continuously from ptr=0; grant order and spacing checked.
  task automatic test_round_robin();
    int ta [4] = '{2, 5, 8, 11};
    int tb_ [4] = '{4, 5, 6, 7};
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int gid [5];
    int gcyc [5];
    int ngr = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    for (int i = 0; i < NREQ; i++) set_op(i, 4'(ta[i]), 4'(tb_[i]));
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 30 && ngr < 5; c++) begin
      #1;
      if (bus.rsp_valid) begin
        n_checks++;
        if (bus.rsp_sum !== 5'(ta[bus.rsp_id] + tb_[bus.rsp_id]))
          $display("FAIL rr_rsp_sum id %0d: got %0d want %0d", bus.rsp_id, bus.rsp_sum, ta[bus.rsp_id] + tb_[bus.rsp_id]);
        else n_pass++;
      end
      if (bus.req_ready != 4'b0000) begin
        for (int j = 0; j < NREQ; j++) if (bus.req_ready[j]) gid[ngr] = j;
        gcyc[ngr] = c;
        ngr++;
      end
      @(negedge clk);
    end
    bus.req_valid = 4'b0000;
    n_checks++; if (ngr !== 5) $display("FAIL rr_grant_count: got %0d want 5 within 30 cycles", ngr); else n_pass++;
    for (int k = 0; k < ngr; k++) begin
      n_checks++; if (gid[k] !== exp_order[k]) $display("FAIL rr_order[%0d]: got %0d want %0d", k, gid[k], exp_order[k]); else n_pass++;
      if (k > 0) begin
        n_checks++; if (gcyc[k] - gcyc[k-1] !== 3) $display("FAIL rr_interval[%0d]: got %0d want 3", k, gcyc[k] - gcyc[k-1]); else n_pass++;
      end
    end
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_sum !== 5'd6 || bus.rsp_id !== 2'd0) $display("FAIL rr_last_rsp: got sum %0d id %0d want sum 6 id 0", bus.rsp_sum, bus.rsp_id); else n_pass++;
    @(negedge clk); #1;
    exp_ops = 5;
    n_checks++; if (bus.ops_cnt !== 8'(exp_ops)) $display("FAIL rr_ops_cnt: got %0d want %0d", bus.ops_cnt, exp_ops); else n_pass++;
  endtask

  // Max operands from requester 3, then ptr must wrap so requester 1 beats 3.
  task automatic test_wrap_ptr();
    set_op(3, 4'd15, 4'd15);
    bus.req_valid = 4'b1000;
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) $display("FAIL wrap_grant3: got %b want 1000", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    set_op(3, 4'd0, 4'd0);
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_sum !== 5'b11110) $display("FAIL wrap_sum30: got %b want 11110", bus.rsp_sum); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd3) $display("FAIL wrap_id3: got %0d want 3", bus.rsp_id); else n_pass++;
    @(negedge clk);
    set_op(1, 4'd3, 4'd7);
    set_op(3, 4'd1, 4'd1);
    bus.req_valid = 4'b1010;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL wrap_ptr0_grant1: got %b want 0010", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_sum !== 5'd10) $display("FAIL wrap_sum10: got %0d want 10", bus.rsp_sum); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd1) $display("FAIL wrap_id1: got %0d want 1", bus.rsp_id); else n_pass++;
    @(negedge clk); #1;
    exp_ops += 2;
    n_checks++; if (bus.ops_cnt !== 8'(exp_ops)) $display("FAIL wrap_ops_cnt: got %0d want %0d", bus.ops_cnt, exp_ops); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0) $display("FAIL wrap_dropped_idle: got ready %b valid %b want 0000 0", bus.req_ready, bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.add_a !== 4'd3 || bus.add_b !== 4'd7) $display("FAIL wrap_operand_hold: got %0d,%0d want 3,7", bus.add_a, bus.add_b); else n_pass++;
  endtask

  // Response stalled 5 cycles; a waiting requester must not be granted meanwhile.
  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    set_op(2, 4'd9, 4'd6);
    bus.req_valid = 4'b0100;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) $display("FAIL bp_grant2: got %b want 0100", bus.req_ready); else n_pass++;
    @(negedge clk);
    set_op(0, 4'd1, 4'd2);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 5'd15 || bus.rsp_id !== 2'd2 || bus.req_ready !== 4'b0000)
        $display("FAIL bp_hold[%0d]: got valid %b sum %0d id %0d ready %b want 1 15 2 0000", c, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.req_ready);
      else n_pass++;
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 5'd15) $display("FAIL bp_release: got valid %b sum %0d want 1 15", bus.rsp_valid, bus.rsp_sum); else n_pass++;
    @(negedge clk); #1;
    exp_ops += 1;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_done_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.ops_cnt !== 8'(exp_ops)) $display("FAIL bp_ops_cnt: got %0d want %0d", bus.ops_cnt, exp_ops); else n_pass++;
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL bp_next_grant0: got %b want 0001", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_sum !== 5'd3 || bus.rsp_id !== 2'd0) $display("FAIL bp_second_rsp: got sum %0d id %0d want 3 0", bus.rsp_sum, bus.rsp_id); else n_pass++;
    @(negedge clk);
    exp_ops += 1;
  endtask

  // One-cycle reset while in EXEC discards the op and clears ptr/ops_cnt.
  task automatic test_reset_mid();
    set_op(1, 4'd5, 4'd5);
    bus.req_valid = 4'b0010;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL rm_grant1: got %b want 0010", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_ops = 0;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rm_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.ops_cnt !== 8'd0) $display("FAIL rm_ops_cnt: got %0d want 0", bus.ops_cnt); else n_pass++;
    n_checks++; if (bus.add_a !== 4'd0) $display("FAIL rm_add_a: got %0d want 0", bus.add_a); else n_pass++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rm_no_rsp[%0d]: got %b want 0", c, bus.rsp_valid); else n_pass++;
    end
    bus.req_valid = 4'b1001;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) $display("FAIL rm_ptr0: got %b want 0001", bus.req_ready); else n_pass++;
    set_op(2, 4'd12, 4'd13);
    bus.req_valid = 4'b0100;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) $display("FAIL rm_grant2: got %b want 0100", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 5'd25 || bus.rsp_id !== 2'd2) $display("FAIL rm_rsp: got valid %b sum %0d id %0d want 1 25 2", bus.rsp_valid, bus.rsp_sum, bus.rsp_id); else n_pass++;
    @(negedge clk); #1;
    exp_ops = 1;
    n_checks++; if (bus.ops_cnt !== 8'(exp_ops)) $display("FAIL rm_ops_cnt_after: got %0d want %0d", bus.ops_cnt, exp_ops); else n_pass++;
  endtask

  // Back-to-back ops from requester 0 until ops_cnt rolls over 255 -> 0.
  task automatic test_ops_wrap();
    set_op(0, 4'd1, 4'd1);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0001;
    for (int k = 1; k <= 256 - exp_ops; k++) begin
      repeat (3) @(negedge clk);
      #1;
      if (k == 255 - exp_ops) begin
        n_checks++; if (bus.ops_cnt !== 8'd255) $display("FAIL wrap_ops_255: got %0d want 255", bus.ops_cnt); else n_pass++;
      end
    end
    bus.req_valid = 4'b0000;
    n_checks++; if (bus.ops_cnt !== 8'd0) $display("FAIL wrap_ops_0: got %0d want 0", bus.ops_cnt); else n_pass++;
    n_checks++; if (bus.rsp_sum !== 5'd2) $display("FAIL wrap_ops_sum: got %0d want 2", bus.rsp_sum); else n_pass++;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_ptr();
    test_backpressure();
    test_reset_mid();
    test_ops_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
